tl_a_async_tx: RTL and testbench

- Write-side (transmit) half of a Gray-pointer clock-domain crossing for the TileLink A channel.
- Accepts A-channel beats with a valid/ready handshake in the wr_clk domain and packs them into one storage word.
- Drives the write port of an external dual-port storage array and publishes a Gray-coded write pointer to the read domain.
- Synchronizes the read domain's Gray pointer back into wr_clk and uses it to generate full, almost-full and fill level.

---
 rtl/tl_a_async_tx.sv | 173 +++++++++++++++++
 tb/tb_tl_a_async_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_a_async_tx.sv
// -----------------------------------------------------------------------------
// tl_a_async_tx
// Write (transmit) half of a Gray-pointer clock-domain crossing for the
// TileLink A channel. Beats accepted in the wr_clk domain are packed into one
// storage word and written into an external dual-port array. A Gray-coded write
// pointer is published to the read domain. The read domain's Gray pointer is
// synchronized back into wr_clk to produce full, almost_full and level.
//
// Ports
//   wr_clk          write-domain clock
//   reset           asynchronous, active-high, shared with the read side
//   a_valid/a_ready A-channel handshake (beat accepted when both are high)
//   a_opcode        TileLink A opcode (0..5 legal, 6/7 dropped)
//   a_size          log2 of transfer bytes
//   a_address       beat address
//   a_data          beat data
//   mem_we          storage write enable (combinational, same cycle as accept)
//   mem_waddr       storage write index
//   mem_wdata       packed {a_opcode, a_size, a_address, a_data}
//   wr_ptr_gray     registered Gray write pointer to the read domain
//   rd_ptr_gray     Gray read pointer from the read domain (async to wr_clk)
//   full            registered full flag
//   almost_full     registered, level >= AF_THRESH
//   level           registered conservative occupancy
//   err_illegal_op  one-cycle pulse per dropped beat
//   err_cnt         saturating count of dropped beats
// -----------------------------------------------------------------------------
module tl_a_async_tx #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6,
    localparam int PTR_WIDTH  = $clog2(DEPTH),
    localparam int WORD_WIDTH = 6 + ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                    wr_clk,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [2:0]              a_opcode,
    input  logic [2:0]              a_size,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    mem_we,
    output logic [PTR_WIDTH-1:0]    mem_waddr,
    output logic [WORD_WIDTH-1:0]   mem_wdata,
    output logic [PTR_WIDTH:0]      wr_ptr_gray,
    input  logic [PTR_WIDTH:0]      rd_ptr_gray,
    output logic                    full,
    output logic                    almost_full,
    output logic [PTR_WIDTH:0]      level,
    output logic                    err_illegal_op,
    output logic [7:0]              err_cnt
);

    localparam logic [PTR_WIDTH:0] AF_LVL = AF_THRESH[PTR_WIDTH:0];

    function automatic logic [PTR_WIDTH:0] bin2gray(input logic [PTR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_WIDTH:0] r_wr_bin;
    logic [PTR_WIDTH:0] r_wr_gray;
    logic [PTR_WIDTH:0] r_sync [SYNC_STAGES];
    logic [PTR_WIDTH:0] r_level;
    logic               r_full;
    logic               r_af;
    logic               r_ready;
    logic               r_err;
    logic [7:0]         r_err_cnt;

    logic               w_fire;
    logic               w_legal;
    logic               w_wr;
    logic [PTR_WIDTH:0] w_wr_bin_next;
    logic [PTR_WIDTH:0] w_wr_gray_next;
    logic [PTR_WIDTH:0] w_rq;
    logic [PTR_WIDTH:0] w_rd_bin;
    logic [PTR_WIDTH:0] w_full_cmp;
    logic               w_full_next;
    logic [PTR_WIDTH:0] w_level_next;
    logic               w_af_next;

    // a_ready comes only from a register; it is held low through reset so an
    // in-flight beat cannot produce a write while reset is asserted.
    assign a_ready  = r_ready;
    assign w_fire   = a_valid & r_ready;
    assign w_legal  = (a_opcode <= 3'd5);
    assign w_wr     = w_fire & w_legal;

    assign mem_we    = w_wr;
    assign mem_waddr = r_wr_bin[PTR_WIDTH-1:0];
    assign mem_wdata = {a_opcode, a_size, a_address, a_data};

    assign w_wr_bin_next  = r_wr_bin + {{PTR_WIDTH{1'b0}}, w_wr};
    assign w_wr_gray_next = bin2gray(w_wr_bin_next);

    assign w_rq     = r_sync[SYNC_STAGES-1];
    assign w_rd_bin = gray2bin(w_rq);

    // Full when the write pointer is exactly one lap ahead: in Gray code that
    // is the read pointer with its two MSBs inverted.
    assign w_full_cmp   = {~w_rq[PTR_WIDTH:PTR_WIDTH-1], w_rq[PTR_WIDTH-2:0]};
    assign w_full_next  = (w_wr_gray_next == w_full_cmp);
    // The synchronized read pointer lags the true one, so this never
    // under-reports occupancy.
    assign w_level_next = w_wr_bin_next - w_rd_bin;
    assign w_af_next    = (w_level_next >= AF_LVL);

    // Read-pointer synchronizer
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Write pointers and status flags
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_wr_bin  <= '0;
            r_wr_gray <= '0;
            r_full    <= 1'b0;
            r_af      <= 1'b0;
            r_level   <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_wr_bin  <= w_wr_bin_next;
            r_wr_gray <= w_wr_gray_next;
            r_full    <= w_full_next;
            r_af      <= w_af_next;
            r_level   <= w_level_next;
            r_ready   <= ~w_full_next;
        end
    end

    // Dropped-beat reporting
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_fire & ~w_legal;
            if (w_fire && !w_legal && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign wr_ptr_gray    = r_wr_gray;
    assign full           = r_full;
    assign almost_full    = r_af;
    assign level          = r_level;
    assign err_illegal_op = r_err;
    assign err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_tl_a_async_tx.sv
module tb_tl_a_async_tx;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int AF    = 6;
    localparam int PW    = $clog2(DEPTH);
    localparam int WW    = 6 + AW + DW;

    logic           wr_clk = 1'b0;
    logic           reset;
    logic           a_valid;
    logic           a_ready;
    logic [2:0]     a_opcode;
    logic [2:0]     a_size;
    logic [AW-1:0]  a_address;
    logic [DW-1:0]  a_data;
    logic           mem_we;
    logic [PW-1:0]  mem_waddr;
    logic [WW-1:0]  mem_wdata;
    logic [PW:0]    wr_ptr_gray;
    logic [PW:0]    rd_ptr_gray;
    logic           full;
    logic           almost_full;
    logic [PW:0]    level;
    logic           err_illegal_op;
    logic [7:0]     err_cnt;

    tl_a_async_tx #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .SYNC_STAGES(SYNC), .AF_THRESH(AF)
    ) dut (
        .wr_clk(wr_clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_opcode(a_opcode), .a_size(a_size),
        .a_address(a_address), .a_data(a_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
        .full(full), .almost_full(almost_full), .level(level),
        .err_illegal_op(err_illegal_op), .err_cnt(err_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: counts of beats written / read as plain integers.
    int  wcnt;
    int  rcnt;
    int  hist[$];
    bit  m_ready;
    bit  m_full;
    bit  m_af;
    int  m_lvl;
    bit  m_err;
    int  m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW:0] gray_of(input int n);
        int b;
        b = n % (2 * DEPTH);
        return PW'(0) + (PW+1)'(b ^ (b >> 1));
    endfunction

    task automatic model_init();
        wcnt = 0; rcnt = 0;
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(0);
        m_ready = 0; m_full = 0; m_af = 0; m_lvl = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_valid = 1'b0; a_opcode = '0; a_size = '0; a_address = '0; a_data = '0;
        rd_ptr_gray = '0;
        #1;
        check_eq("rst_gray",  wr_ptr_gray, 0);
        check_eq("rst_full",  full, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_errcnt", err_cnt, 0);
        check_eq("rst_mem_we", mem_we, 0);
        repeat (2) @(posedge wr_clk);
        #1 reset = 1'b0;
        model_init();
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance model.
    task automatic step(input logic v, input logic [2:0] op, input logic [DW-1:0] dt, input bit rd_adv);
        logic [2:0]    sz;
        logic [AW-1:0] ad;
        bit            fire;
        bit            legal;
        int            rq;
        sz = 3'($urandom);
        ad = $urandom;
        if (rd_adv && rcnt < wcnt) rcnt++;
        a_valid = v; a_opcode = op; a_size = sz; a_address = ad; a_data = dt;
        rd_ptr_gray = gray_of(rcnt);
        hist.push_back(rcnt);
        @(negedge wr_clk);
        check_eq("a_ready",     a_ready, m_ready);
        check_eq("full",        full, m_full);
        check_eq("almost_full", almost_full, m_af);
        check_eq("level",       level, m_lvl);
        check_eq("wr_ptr_gray", wr_ptr_gray, gray_of(wcnt));
        check_eq("err_pulse",   err_illegal_op, m_err);
        check_eq("err_cnt",     err_cnt, m_cnt);
        fire  = v && m_ready;
        legal = (op <= 3'd5);
        check_eq("mem_we", mem_we, fire && legal);
        if (fire && legal) begin
            check_eq("mem_waddr", mem_waddr, wcnt % DEPTH);
            check_eq("mem_wdata", mem_wdata, {op, sz, ad, dt});
            wcnt++;
        end
        m_err = fire && !legal;
        if (m_err && m_cnt < 255) m_cnt++;
        rq      = hist[hist.size() - 1 - SYNC];
        m_lvl   = (wcnt - rq) % (2 * DEPTH);
        m_full  = (m_lvl == DEPTH);
        m_af    = (m_lvl >= AF);
        m_ready = !m_full;
        @(posedge wr_clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        model_init();
        do_reset();

        // Reset release
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("ready_after_rst", a_ready, 1);

        // Fill with reader idle, then one held beat
        for (int i = 0; i < DEPTH; i++) step(1, 3'd0, DW'(32'h10 + i), 0);
        step(1, 3'd0, DW'(32'h18), 0);
        check_eq("fill_full",  full, 1);
        check_eq("fill_ready", a_ready, 0);
        check_eq("fill_level", level, 8);
        check_eq("fill_gray",  wr_ptr_gray, 4'b1100);

        // Drain visibility: one read, seen on the third edge
        step(1, 3'd0, DW'(32'h18), 1);
        step(1, 3'd0, DW'(32'h18), 0);
        check_eq("drain_full_e2", full, 1);
        step(1, 3'd0, DW'(32'h18), 0);
        check_eq("drain_full_e3", full, 0);
        check_eq("drain_lvl_e3",  level, 7);
        step(1, 3'd0, DW'(32'h18), 0);
        step(0, 3'd0, 0, 0);

        // Illegal opcode between two legal beats
        repeat (8) step(0, 0, 0, 1);
        step(1, 3'd4, DW'(32'hA1), 0);
        step(1, 3'd7, DW'(32'hA2), 0);
        step(1, 3'd1, DW'(32'hA3), 0);
        step(0, 0, 0, 0);
        check_eq("illegal_cnt", err_cnt, 1);

        // Wrap with the reader two entries behind
        do_reset();
        step(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 3'($urandom_range(0, 5)), $urandom, (wcnt - rcnt) >= 2);
        step(0, 0, 0, 0);
        check_eq("wrap_count", wr_ptr_gray, gray_of(20));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 7) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            step($urandom_range(0, 3) != 0, op, $urandom, $urandom_range(0, 2) != 0);
        end

        // Error-counter saturation
        repeat (10) step(0, 0, 0, 1);
        for (int i = 0; i < 260; i++) step(1, 3'(6 + (i % 2)), $urandom, 1);
        step(0, 0, 0, 0);
        check_eq("err_sat", err_cnt, 255);

        // Asynchronous reset mid-beat with level 5
        do_reset();
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 3'd0, DW'(i), 0);
        step(0, 0, 0, 0);
        check_eq("pre_rst_level", level, 5);
        a_valid = 1'b1; a_opcode = 3'd0; a_data = DW'(32'h55);
        #2;
        check_eq("pre_rst_we", mem_we, 1);
        reset = 1'b1;
        #1;
        check_eq("arst_we",     mem_we, 0);
        check_eq("arst_ready",  a_ready, 0);
        check_eq("arst_full",   full, 0);
        check_eq("arst_af",     almost_full, 0);
        check_eq("arst_level",  level, 0);
        check_eq("arst_gray",   wr_ptr_gray, 0);
        check_eq("arst_err",    err_illegal_op, 0);
        check_eq("arst_errcnt", err_cnt, 0);
        do_reset();
        step(0, 0, 0, 0);
        step(1, 3'd2, DW'(32'h77), 0);
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
